// File: rtl/fp_res_pkg.sv
// Shared types for the FP32 multiplier result buffer: result classes, the stored
// entry layout and the combinational classifier.
package fp_res_pkg;

    typedef enum logic [2:0] {
        ZERO   = 3'd0,
        DENORM = 3'd1,
        NORMAL = 3'd2,
        INF    = 3'd3,
        QNAN   = 3'd4,
        SNAN   = 3'd5
    } fp_class_e;

    localparam logic [7:0] EXP_MAX  = 8'hFF;
    localparam logic [7:0] EXP_MAXN = 8'hFE;

    typedef struct packed {
        logic [31:0] data;
        fp_class_e   cls;
        logic        ovrf;
        logic        udrf;
        logic [2:0]  r_mode;
    } fp_res_entry_t;

    function automatic fp_class_e classify(input logic [31:0] z);
        logic [7:0]  e;
        logic [22:0] m;
        e = z[30:23];
        m = z[22:0];
        if (e == 8'h00)
            return (m == '0) ? ZERO : DENORM;
        else if (e == EXP_MAX) begin
            if (m == '0)
                return INF;
            return m[22] ? QNAN : SNAN;
        end
        return NORMAL;
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// First-word-fall-through FIFO of result entries. The head entry is kept in a
// register so the outputs are reset to zero and hold their last value when empty.
module fp_res_fifo
    import fp_res_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_req,
    input  fp_res_entry_t            din,
    input  logic                     out_ready,
    output fp_res_entry_t            dout,
    output logic                     out_valid,
    output logic                     push_ok,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    fp_res_entry_t   mem [DEPTH];
    fp_res_entry_t   head_q;
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]     cnt_q;
    logic            pop;

    assign full      = (cnt_q == CNT_FULL);
    assign empty     = (cnt_q == '0);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push_ok   = push_req && (!full || pop);
    assign rd_nxt    = rd_ptr + 1'b1;
    assign count     = cnt_q;
    assign dout      = head_q;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_nxt;
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            // Next head comes from storage if another entry is queued behind it,
            // otherwise straight from the incoming push. A lone pop holds the value.
            if (pop) begin
                if (cnt_q > CNT_ONE)
                    head_q <= mem[rd_nxt];
                else if (push_ok)
                    head_q <= din;
            end else if (push_ok && empty) begin
                head_q <= din;
            end
        end
    end

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Capture stage for FP32 multiplier results: classify, buffer, count events.
// Optional FP_RES_FLAG_CHECK_EN adds a sticky flag_mismatch output.
module fp_mul_result_buffer
    import fp_res_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [31:0]              fp_Z,
    input  logic                     ovrf,
    input  logic                     udrf,
    input  logic [2:0]               r_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic [2:0]               out_class,
    output logic                     out_ovrf,
    output logic                     out_udrf,
    output logic [2:0]               out_r_mode,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         ovrf_cnt,
    output logic [CNT_W-1:0]         udrf_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     cnt_clr
`ifdef FP_RES_FLAG_CHECK_EN
    ,
    output logic                     flag_mismatch
`endif
);

    fp_class_e     in_cls;
    fp_res_entry_t in_entry, head;
    logic          push_ok, drop;

    assign in_cls   = classify(fp_Z);
    assign in_entry = '{data: fp_Z, cls: in_cls, ovrf: ovrf, udrf: udrf, r_mode: r_mode};
    assign drop     = in_valid && !push_ok;

    fp_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (in_valid),
        .din       (in_entry),
        .out_ready (out_ready),
        .dout      (head),
        .out_valid (out_valid),
        .push_ok   (push_ok),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign out_data   = head.data;
    assign out_class  = head.cls;
    assign out_ovrf   = head.ovrf;
    assign out_udrf   = head.udrf;
    assign out_r_mode = head.r_mode;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovrf_cnt <= '0;
            udrf_cnt <= '0;
            drop_cnt <= '0;
        end else if (cnt_clr) begin
            ovrf_cnt <= '0;
            udrf_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok && ovrf)
                ovrf_cnt <= sat_inc(ovrf_cnt);
            if (push_ok && udrf)
                udrf_cnt <= sat_inc(udrf_cnt);
            if (drop)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef FP_RES_FLAG_CHECK_EN
    logic [7:0] in_e;
    logic       ov_bad, ud_bad;

    // An overflowed result should saturate to INF or the largest finite value.
    assign in_e   = fp_Z[30:23];
    assign ov_bad = ovrf && (in_cls != INF) && (in_e != EXP_MAXN);
    assign ud_bad = udrf && (in_cls != ZERO) && (in_cls != DENORM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flag_mismatch <= 1'b0;
        else if (cnt_clr)
            flag_mismatch <= 1'b0;
        else if (push_ok && (ov_bad || ud_bad))
            flag_mismatch <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Directed bench for fp_mul_result_buffer; expected values are hand-computed.
module tb_fp_mul_result_buffer;
    import fp_res_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, ovrf, udrf, out_ready, cnt_clr;
    logic [31:0]       fp_Z;
    logic [2:0]        r_mode;
    logic              out_valid, out_ovrf, out_udrf, full, empty;
    logic [31:0]       out_data;
    logic [2:0]        out_class, out_r_mode;
    logic [3:0]        count;
    logic [CNT_W-1:0]  ovrf_cnt, udrf_cnt, drop_cnt;
`ifdef FP_RES_FLAG_CHECK_EN
    logic              flag_mismatch;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_mul_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .fp_Z(fp_Z),
        .ovrf(ovrf), .udrf(udrf), .r_mode(r_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
        .out_ovrf(out_ovrf), .out_udrf(out_udrf), .out_r_mode(out_r_mode),
        .full(full), .empty(empty), .count(count), .ovrf_cnt(ovrf_cnt),
        .udrf_cnt(udrf_cnt), .drop_cnt(drop_cnt), .cnt_clr(cnt_clr)
`ifdef FP_RES_FLAG_CHECK_EN
        , .flag_mismatch(flag_mismatch)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] z, input logic o, input logic u, input logic [2:0] rm);
        in_valid = 1'b1;
        fp_Z     = z;
        ovrf     = o;
        udrf     = u;
        r_mode   = rm;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        fp_Z     = '0;
        ovrf     = 1'b0;
        udrf     = 1'b0;
        r_mode   = '0;
    endtask

    // Check the head entry, then pop it.
    task automatic pop_chk(input string tag, input logic [31:0] d, input logic [2:0] c,
                           input logic o, input logic u);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  out_data, d);
        chk({tag, ".class"}, 32'(out_class), 32'(c));
        chk({tag, ".ovrf"},  32'(out_ovrf), 32'(o));
        chk({tag, ".udrf"},  32'(out_udrf), 32'(u));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        idle();
        #12;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.full",  32'(full), 32'd0);
        chk("rst.data",  out_data, 32'd0);
        chk("rst.class", 32'(out_class), 32'd0);
        chk("rst.rmode", 32'(out_r_mode), 32'd0);
        chk("rst.cnts",  32'({ovrf_cnt, udrf_cnt, drop_cnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single entry, FWFT latency of one edge
        drv(32'h3F800000, 1'b0, 1'b0, 3'b001);
        tick();
        idle();
        chk("t1.valid", 32'(out_valid), 32'd1);
        chk("t1.data",  out_data, 32'h3F800000);
        chk("t1.class", 32'(out_class), 32'(NORMAL));
        chk("t1.rmode", 32'(out_r_mode), 32'd1);
        chk("t1.count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1.empty", 32'(empty), 32'd1);
        chk("t1.vld0",  32'(out_valid), 32'd0);
        chk("t1.hold",  out_data, 32'h3F800000);

        // Classification and flag counters
        drv(32'h7F800000, 1'b1, 1'b0, 3'd2); tick();
        drv(32'h00000000, 1'b0, 1'b1, 3'd3); tick();
        drv(32'h7FC00000, 1'b0, 1'b0, 3'd0); tick();
        drv(32'h00000001, 1'b0, 1'b0, 3'd0); tick();
        drv(32'h7FA00000, 1'b0, 1'b0, 3'd0); tick();
        idle();
        chk("t2.count", 32'(count), 32'd5);
        chk("t2.ocnt",  32'(ovrf_cnt), 32'd1);
        chk("t2.ucnt",  32'(udrf_cnt), 32'd1);
        pop_chk("t2.inf",  32'h7F800000, INF,    1'b1, 1'b0);
        pop_chk("t2.zero", 32'h00000000, ZERO,   1'b0, 1'b1);
        pop_chk("t2.qnan", 32'h7FC00000, QNAN,   1'b0, 1'b0);
        pop_chk("t2.den",  32'h00000001, DENORM, 1'b0, 1'b0);
        pop_chk("t2.snan", 32'h7FA00000, SNAN,   1'b0, 1'b0);
        chk("t2.empty", 32'(empty), 32'd1);

        // Fill to full; ninth is dropped and its ovrf is not counted
        for (int i = 0; i < 8; i++) begin
            drv(32'h40000000 + 32'(i), 1'b0, 1'b0, 3'd0);
            tick();
        end
        chk("t3.full",  32'(full), 32'd1);
        chk("t3.count", 32'(count), 32'd8);
        drv(32'h40000008, 1'b1, 1'b0, 3'd0);
        tick();
        idle();
        chk("t3.drop",  32'(drop_cnt), 32'd1);
        chk("t3.ocnt",  32'(ovrf_cnt), 32'd1);
        chk("t3.cnt8",  32'(count), 32'd8);
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("t3.d%0d", i), 32'h40000000 + 32'(i), NORMAL, 1'b0, 1'b0);
        chk("t3.empty", 32'(empty), 32'd1);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) begin
            drv(32'h40000010 + 32'(i), 1'b0, 1'b0, 3'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(32'h40000020 + 32'(k), 1'b0, 1'b0, 3'd0);
            chk($sformatf("t4.h%0d", k), out_data, 32'h40000010 + 32'(k));
            tick();
            chk($sformatf("t4.c%0d", k), 32'(count), 32'd8);
        end
        idle();
        out_ready = 1'b0;
        chk("t4.drop", 32'(drop_cnt), 32'd1);
        for (int i = 4; i < 8; i++)
            pop_chk($sformatf("t4.a%0d", i), 32'h40000010 + 32'(i), NORMAL, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            pop_chk($sformatf("t4.b%0d", k), 32'h40000020 + 32'(k), NORMAL, 1'b0, 1'b0);
        chk("t4.empty", 32'(empty), 32'd1);

        // Clear beats a same-cycle increment; then saturation with streaming
        cnt_clr = 1'b1;
        drv(32'h3F800000, 1'b1, 1'b1, 3'd0);
        tick();
        cnt_clr = 1'b0;
        chk("t5.clr.o", 32'(ovrf_cnt), 32'd0);
        chk("t5.clr.d", 32'(drop_cnt), 32'd0);
        out_ready = 1'b1;
        drv(32'h7F800000, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("t5.c%0d", i), 32'(count), 32'd1);
        end
        idle();
        chk("t5.sat",  32'(ovrf_cnt), 32'd15);
        chk("t5.ucnt", 32'(udrf_cnt), 32'd0);
        chk("t5.drop", 32'(drop_cnt), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("t5.empty", 32'(empty), 32'd1);

        // Asynchronous reset with entries stored
        for (int i = 0; i < 5; i++) begin
            drv(32'h41000000 + 32'(i), (i == 2), 1'b0, 3'd5);
            tick();
        end
        idle();
        chk("t6.pre", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.valid", 32'(out_valid), 32'd0);
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.cnts",  32'({ovrf_cnt, udrf_cnt, drop_cnt}), 32'd0);
        chk("t6.data",  out_data, 32'd0);
        chk("t6.rmode", 32'(out_r_mode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6.empty", 32'(empty), 32'd1);

`ifdef FP_RES_FLAG_CHECK_EN
        chk("t7.init", 32'(flag_mismatch), 32'd0);
        drv(32'h7F7FFFFF, 1'b1, 1'b0, 3'd0); tick();
        chk("t7.maxn", 32'(flag_mismatch), 32'd0);
        drv(32'h7F800000, 1'b1, 1'b0, 3'd0); tick();
        drv(32'h00000001, 1'b0, 1'b1, 3'd0); tick();
        chk("t7.ok", 32'(flag_mismatch), 32'd0);
        drv(32'h3F800000, 1'b1, 1'b0, 3'd0); tick();
        chk("t7.set", 32'(flag_mismatch), 32'd1);
        drv(32'h3F800000, 1'b0, 1'b0, 3'd0); tick();
        idle();
        chk("t7.stky", 32'(flag_mismatch), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t7.clr", 32'(flag_mismatch), 32'd0);
        drv(32'h3F800000, 1'b0, 1'b1, 3'd0); tick();
        idle();
        chk("t7.ud", 32'(flag_mismatch), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mul_result_buffer.md
Name: fp_mul_result_buffer

Overview:
Downstream capture stage for the FP32 multiplier.
- Samples each valid result (fp_Z, ovrf, udrf) together with the rounding mode it was issued with.
- Classifies the result and stores it in a first-word-fall-through FIFO.
- Hands entries to the consumer over a valid/ready handshake.
- Keeps saturating event counters for overflow, underflow and dropped results.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  multiplier result valid this cycle
- fp_Z  in  32  multiplier result
- ovrf  in  1  overflow flag from the multiplier
- udrf  in  1  underflow flag from the multiplier
- r_mode  in  3  rounding mode tag of this result
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts the head entry
- out_data  out  32  head result
- out_class  out  3  head classification (fp_class_e)
- out_ovrf  out  1  head overflow flag
- out_udrf  out  1  head underflow flag
- out_r_mode  out  3  head rounding mode
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  $clog2(DEPTH)+1  occupancy
- ovrf_cnt  out  CNT_W  accepted results with ovrf=1
- udrf_cnt  out  CNT_W  accepted results with udrf=1
- drop_cnt  out  CNT_W  results lost because the FIFO was full
- cnt_clr  in  1  synchronous clear of the three counters

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - FIFO pointers 0, count=0, empty=1, full=0, out_valid=0.
  - All counters 0.
  - out_data, out_class, out_ovrf, out_udrf and out_r_mode are 0.
- Reset mid-operation discards every stored entry. No partial pop is visible afterwards.
- Classification is combinational on the input and stored alongside the entry. Fields: e=fp_Z[30:23], m=fp_Z[22:0].
  - e==0, m==0: ZERO
  - e==0, m!=0: DENORM
  - e==FF, m==0: INF
  - e==FF, m[22]=1: QNAN
  - e==FF, m[22]=0, m!=0: SNAN
  - otherwise: NORMAL
- Push: push = in_valid && (!full || pop).
- Pop: pop = out_valid && out_ready.
- Simultaneous push and pop:
  - Allowed when full; count stays at DEPTH.
  - Allowed when partially filled; count unchanged.
  - When empty, only the push occurs (no bypass).
- Latency: an entry accepted at edge N appears on the out_* signals with out_valid=1 after edge N.
  - out_* signals reflect the head entry whenever !empty (FWFT).
  - The out_* values are don't-care when empty. Implementation holds the last value.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally.
  - full = (count==DEPTH).
  - empty = (count==0).
- Drop: in_valid && full && !pop discards the input.
  - drop_cnt increments.
  - ovrf_cnt and udrf_cnt do not count dropped results.
- Counters:
  - Saturate at all-ones.
  - Increment on accepted push with the corresponding flag.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- out_valid depends on the FIFO only. out_ready has no combinational path to any output.

Optional Feature:
- Macro: FP_RES_FLAG_CHECK_EN.
- When defined, adds output flag_mismatch (1 bit, sticky).
  - Sets on an accepted push where ovrf=1 and class is not INF and e != FE.
  - Also sets where udrf=1 and class is not ZERO or DENORM.
  - Cleared by rst_n or cnt_clr.
- When not defined, the port and its logic are absent.

Decomposition:
- Package fp_res_pkg contains:
  - typedef enum logic [2:0] fp_class_e {ZERO, DENORM, NORMAL, INF, QNAN, SNAN}.
  - Entry struct fp_res_entry_t {data, cls, ovrf, udrf, r_mode} (40 bits).
  - Function classify(logic [31:0]) returning fp_class_e.
  - Exponent constants EXP_MAX=8'hFF, EXP_MAXN=8'hFE.
- Natural sub-module: fp_res_fifo.
  - Generic FWFT FIFO of fp_res_entry_t, parameterised by DEPTH.
  - Outputs push_ok, count, full and empty.
- The top level holds classification, counters and the optional check.

Test Plan:
- Reset, then push 0x3F800000 (ovrf=0, udrf=0, r_mode=3'b001). Next cycle out_valid=1, out_data=0x3F800000, out_class=NORMAL, count=1. out_ready=1 → empty=1.
- Push 0x7F800000 with ovrf=1, then 0x00000000 with udrf=1, then 0x7FC00000. Classes are INF, ZERO, QNAN. ovrf_cnt=1, udrf_cnt=1.
- out_ready=0, push 9 results 0x40000000..0x40000008. full=1 after 8, the 9th is dropped, drop_cnt=1. Drain order matches input order.
- While full, in_valid=1 and out_ready=1 for 4 cycles. count stays 8, drop_cnt unchanged, outputs stream in order.
- With 5 entries stored, assert rst_n=0 asynchronously between edges. Outputs clear immediately: out_valid=0, count=0, counters 0.
- With FP_RES_FLAG_CHECK_EN defined, push 0x3F800000 with ovrf=1 → flag_mismatch=1 and it stays set. cnt_clr → 0.
